logic_shift_unit: RTL
=====================

# logic_shift_unit

Parametrised logic/shift execution unit for the MIPS ALU datapath. Performs AND, OR, XOR, NOR in one cycle and SLL, SRL, SRA iteratively at a configurable number of bit positions per cycle. Sits beside the arithmetic unit and uses a valid/ready handshake on both sides so the control path can stall it. It holds one operation at a time.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8.
- STEP, 4: maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH/2.
- SHW (local), log2(WIDTH): shift-amount width.

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation.
- A  in  WIDTH  operand A; shift source for shift ops.
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift ops, upper bits ignored.
- AluOp  in  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLL, 101 SRL, 110 SRA, 111 illegal.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- out_err  out  1  qualifies result; 1 when the op was illegal.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, out_valid=0. Operation accepted on in_valid && in_ready. A, B, AluOp are sampled only at acceptance and ignored otherwise.
- At acceptance of a logic op (000–011), the result register is loaded with A&B, A|B, A^B, or ~(A|B). out_err is loaded with 0. Next state is DONE.
- At acceptance of 111, the result register is loaded with 0 and out_err with 1. Next state is DONE.
- At acceptance of a shift op:
  - the accumulator is loaded with A;
  - cnt is loaded with B[SHW-1:0];
  - out_err is loaded with 0;
  - if cnt==0, next state is DONE with result=A; otherwise next state is SHIFT.
- SHIFT: each cycle, k = min(STEP, cnt).
  - The accumulator shifts by k: left with zero fill for SLL, right with zero fill for SRL, right with fill of the original A[WIDTH-1] for SRA.
  - cnt -= k.
  - When the new cnt is 0, next state is DONE.
  - in_ready=0 and out_valid=0 throughout.
- DONE: out_valid=1; result and out_err are held stable. On out_ready, next state is IDLE. in_ready=0 in DONE; no accept in the same cycle as drain.
- The result register and the accumulator are one and the same register.
- Arithmetic: all results are WIDTH bits; shifts never widen. A shift by WIDTH-1 is the maximum; amounts ≥ WIDTH cannot occur because B is truncated to SHW bits.

## Timing
- Reset values: state=IDLE, in_ready=1 in the first cycle after reset, out_valid=0, result=0, out_err=0, cnt=0.
- Reset mid-operation, in SHIFT or DONE: the operation is discarded and all reset values apply on the next edge. An undelivered result is lost.
- Latency, defined as the acceptance edge to the first cycle out_valid=1:
  - logic op, illegal op, or zero-amount shift: 1 cycle;
  - shift by n > 0: 1 + ceil(n/STEP) cycles.
- Throughput: at most one operation per 2 cycles (accept, then drain).
- Backpressure: out_valid, result, and out_err stay unchanged for as long as out_ready=0.
- out_ready while out_valid=0 has no effect.
- in_valid while in_ready=0 has no effect. The producer must hold the operation itself.
- Simultaneous rst and handshake: rst wins.

## Test plan
- Logic ops, WIDTH=32: A=0xF0F0_1234, B=0x0FF0_FFFF.
  - AND gives 0x00F0_1234; OR gives 0xFFF0_FFFF; XOR gives 0xFF00_EDCB; NOR gives 0x000F_0000.
  - Each has out_valid 1 cycle after accept and out_err=0.
- Shift latency, STEP=4:
  - SLL of A=0x0000_0001 with B=5 gives 0x0000_0020, out_valid 3 cycles after accept.
  - SRA of A=0x8000_0000 with B=31 gives 0xFFFF_FFFF, out_valid 9 cycles after accept.
  - SRL with B=0 gives A after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - result is stable and in_ready=0 throughout.
  - A new in_valid is ignored.
  - After out_ready=1, the next cycle is IDLE with in_ready=1.
- Illegal op: AluOp=111 with any A/B gives result=0 and out_err=1 after 1 cycle. The next legal op returns out_err=0.
- Reset mid-shift: start SRL of A=0xFFFF_FFFF with B=20. Assert rst in the 3rd SHIFT cycle.
  - Next cycle: out_valid=0, result=0, in_ready=1.
  - A subsequent AND completes normally.
- Parameter sweep: WIDTH=16 with STEP=1, and WIDTH=64 with STEP=32. Random ops are compared against a reference model, including every shift amount 0..WIDTH-1, and latency is checked against the formula.

Source files
------------

// File: rtl/logic_shift_unit.sv
// Logic/shift execution unit: single-cycle AND/OR/XOR/NOR and iterative SLL/SRL/SRA
// at up to STEP bit positions per cycle, with valid/ready handshakes on both sides.
module logic_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       AluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_err
);

    localparam int unsigned     SHW     = $clog2(WIDTH);
    localparam logic [SHW-1:0]  StepAmt = SHW'(STEP);

    typedef enum logic [1:0] {StIdle, StShift, StDone} stateType;

    stateType         state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [1:0]       shiftOp;
    logic             fillBit;
    logic             errFlag;
    logic             inRdy;
    logic             outVld;

    logic [SHW-1:0]     stepAmt;
    logic [SHW-1:0]     cntNext;
    logic [2*WIDTH-1:0] fillWide;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   logicRes;

    always_comb begin
        stepAmt  = (cnt < StepAmt) ? cnt : StepAmt;
        cntNext  = cnt - stepAmt;
        // Arithmetic right shift pulls the latched sign of the original A into the top.
        fillWide = {{WIDTH{fillBit}}, acc} >> stepAmt;
        case (shiftOp)
            2'b00:   shifted = acc << stepAmt;
            2'b01:   shifted = acc >> stepAmt;
            default: shifted = fillWide[WIDTH-1:0];
        endcase
    end

    always_comb begin
        unique case (AluOp[1:0])
            2'b00: logicRes = A & B;
            2'b01: logicRes = A | B;
            2'b10: logicRes = A ^ B;
            2'b11: logicRes = ~(A | B);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            inRdy   <= 1'b1;
            outVld  <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            shiftOp <= 2'b00;
            fillBit <= 1'b0;
            errFlag <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        inRdy   <= 1'b0;
                        errFlag <= 1'b0;
                        if (AluOp == 3'b111) begin
                            acc     <= '0;
                            errFlag <= 1'b1;
                            outVld  <= 1'b1;
                            state   <= StDone;
                        end else if (!AluOp[2]) begin
                            acc    <= logicRes;
                            outVld <= 1'b1;
                            state  <= StDone;
                        end else begin
                            acc     <= A;
                            cnt     <= B[SHW-1:0];
                            shiftOp <= AluOp[1:0];
                            fillBit <= A[WIDTH-1];
                            if (B[SHW-1:0] == '0) begin
                                outVld <= 1'b1;
                                state  <= StDone;
                            end else begin
                                state <= StShift;
                            end
                        end
                    end
                end
                StShift: begin
                    acc <= shifted;
                    cnt <= cntNext;
                    if (cntNext == '0) begin
                        outVld <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        outVld <= 1'b0;
                        inRdy  <= 1'b1;
                        state  <= StIdle;
                    end
                end
                default: begin
                    outVld <= 1'b0;
                    inRdy  <= 1'b1;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = inRdy;
    assign out_valid = outVld;
    assign result    = acc;
    assign out_err   = errFlag;

endmodule
